// File: rtl/cv32e40x_pkg.sv
// Shared types for the cv32e40x EX-stage multiplier.
// The sequencer's short-path option is controlled by the macro CV32E40X_MULT_SHORT_EN.
package cv32e40x_pkg;

   // RV32M multiply flavours handled by the sequencer
   typedef enum logic [1:0] {
      MUL    = 2'b00,
      MULH   = 2'b01,
      MULHSU = 2'b10,
      MULHU  = 2'b11
   } mul_op_e;

   // One state per 16x16 partial product, plus a hold state for an unconsumed result
   typedef enum logic [2:0] {
      ALBL = 3'd0,
      ALBH = 3'd1,
      AHBL = 3'd2,
      AHBH = 3'd3,
      DONE = 3'd4
   } mult_state_e;

   // Partial-product shift amounts
   localparam int unsigned SHIFT_MID = 16;
   localparam int unsigned SHIFT_TOP = 32;

   // Widen a 16-bit half to the 17-bit multiplier input using the given top bit
   function automatic logic [16:0] ext17(input logic [15:0] half, input logic top);
      return {top, half};
   endfunction

endpackage

// File: rtl/cv32e40x_mult_17x17.sv
// Combinational signed 17x17 -> 34 multiplier shared by all sequencer passes.
module cv32e40x_mult_17x17 (
   input  logic signed [16:0] op_a_i,
   input  logic signed [16:0] op_b_i,
   output logic signed [33:0] product_o
);

   logic signed [33:0] a_wide_s;
   logic signed [33:0] b_wide_s;

   // Sign-extend both operands to the product width and multiply
   always_comb begin
      a_wide_s  = {{17{op_a_i[16]}}, op_a_i};
      b_wide_s  = {{17{op_b_i[16]}}, op_b_i};
      product_o = a_wide_s * b_wide_s;
   end

endmodule

// File: rtl/cv32e40x_mult_seq_checker.sv
// Protocol checker for cv32e40x_mult_seq: an accepted-pending instruction must not
// change its operator or operands while enable_i stays high.
module cv32e40x_mult_seq_checker
   import cv32e40x_pkg::*;
(
   input logic        clk,
   input logic        rst_n,
   input logic        enable_i,
   input mul_op_e     operator_i,
   input logic [31:0] op_a_i,
   input logic [31:0] op_b_i,
   input logic        ex_ready_i,
   input logic        ready_o
);

   property p_inputs_stable;
      @(posedge clk) disable iff (!rst_n)
         (enable_i && !(ready_o && ex_ready_i)) |=>
            (!enable_i || ($stable(operator_i) && $stable(op_a_i) && $stable(op_b_i)));
   endproperty

   a_inputs_stable: assert property (p_inputs_stable)
      else $error("mult_seq: operator/operands changed before the result was consumed");

endmodule

// File: rtl/cv32e40x_mult_seq.sv
// Multi-cycle RV32M multiplier sequencer: four 16-bit partial products through one
// shared 17x17 signed multiplier, accumulated into a 64-bit sum.
// Optional feature macro: CV32E40X_MULT_SHORT_EN (single-cycle MUL when both upper halves are zero).
module cv32e40x_mult_seq
   import cv32e40x_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable_i,
   input  mul_op_e     operator_i,
   input  logic [31:0] op_a_i,
   input  logic [31:0] op_b_i,
   input  logic        ex_ready_i,
   output logic [31:0] result_o,
   output logic        ready_o
);

   mult_state_e        state_r;
   mult_state_e        pass_next_s;
   logic [63:0]        acc_r;
   logic [31:0]        result_r;

   logic               ah_sign_s;
   logic               bh_sign_s;
   logic signed [16:0] mul_a_s;
   logic signed [16:0] mul_b_s;
   logic signed [33:0] prod_s;
   logic [63:0]        prod_ext_s;
   logic [63:0]        addend_s;
   logic [63:0]        acc_next_s;
   logic [31:0]        word_s;
   logic               short_s;
   logic               final_s;

`ifdef CV32E40X_MULT_SHORT_EN
   assign short_s = (operator_i == MUL) && (op_a_i[31:16] == 16'h0000) && (op_b_i[31:16] == 16'h0000);
`else
   assign short_s = 1'b0;
`endif

   // Upper halves are signed only for the operand the instruction treats as signed
   assign ah_sign_s = ((operator_i == MULH) || (operator_i == MULHSU)) ? op_a_i[31] : 1'b0;
   assign bh_sign_s = (operator_i == MULH) ? op_b_i[31] : 1'b0;

   // Pick the 17-bit multiplier inputs for the current pass
   always_comb begin
      mul_a_s = ext17(op_a_i[15:0], 1'b0);
      mul_b_s = ext17(op_b_i[15:0], 1'b0);
      case (state_r)
         ALBL: begin
            mul_a_s = ext17(op_a_i[15:0], 1'b0);
            mul_b_s = ext17(op_b_i[15:0], 1'b0);
         end
         ALBH: begin
            mul_a_s = ext17(op_a_i[15:0], 1'b0);
            mul_b_s = ext17(op_b_i[31:16], bh_sign_s);
         end
         AHBL: begin
            mul_a_s = ext17(op_a_i[31:16], ah_sign_s);
            mul_b_s = ext17(op_b_i[15:0], 1'b0);
         end
         AHBH: begin
            mul_a_s = ext17(op_a_i[31:16], ah_sign_s);
            mul_b_s = ext17(op_b_i[31:16], bh_sign_s);
         end
         default: begin
            mul_a_s = ext17(op_a_i[15:0], 1'b0);
            mul_b_s = ext17(op_b_i[15:0], 1'b0);
         end
      endcase
   end

   cv32e40x_mult_17x17 u_mult (
      .op_a_i    (mul_a_s),
      .op_b_i    (mul_b_s),
      .product_o (prod_s)
   );

   assign prod_ext_s = {{30{prod_s[33]}}, prod_s};

   // Align the partial product to its weight and add it to the running sum
   always_comb begin
      addend_s = prod_ext_s;
      case (state_r)
         ALBL:    addend_s = prod_ext_s;
         ALBH:    addend_s = prod_ext_s << SHIFT_MID;
         AHBL:    addend_s = prod_ext_s << SHIFT_MID;
         AHBH:    addend_s = prod_ext_s << SHIFT_TOP;
         default: addend_s = prod_ext_s;
      endcase
      acc_next_s = acc_r + addend_s;
      word_s     = (operator_i == MUL) ? acc_next_s[31:0] : acc_next_s[63:32];
   end

   // Decide whether this pass completes the instruction and which pass follows
   always_comb begin
      final_s     = 1'b0;
      pass_next_s = ALBL;
      case (state_r)
         ALBL: begin
            final_s     = short_s;
            pass_next_s = ALBH;
         end
         ALBH: begin
            final_s     = 1'b0;
            pass_next_s = AHBL;
         end
         AHBL: begin
            final_s     = (operator_i == MUL);
            pass_next_s = AHBH;
         end
         AHBH: begin
            final_s     = 1'b1;
            pass_next_s = ALBL;
         end
         default: begin
            final_s     = 1'b0;
            pass_next_s = ALBL;
         end
      endcase
   end

   // Handshake outputs: combinational result in the final pass, held result in DONE
   always_comb begin
      ready_o  = 1'b1;
      result_o = 32'h0000_0000;
      if (!enable_i) begin
         ready_o  = 1'b1;
         result_o = 32'h0000_0000;
      end else if (state_r == DONE) begin
         ready_o  = 1'b1;
         result_o = result_r;
      end else if (final_s) begin
         ready_o  = 1'b1;
         result_o = word_s;
      end else begin
         ready_o  = 1'b0;
         result_o = 32'h0000_0000;
      end
   end

   // Pass sequencing, accumulation and result hold; a dropped enable flushes everything
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= ALBL;
         acc_r    <= 64'h0;
         result_r <= 32'h0000_0000;
      end else if (!enable_i) begin
         state_r  <= ALBL;
         acc_r    <= 64'h0;
      end else begin
         case (state_r)
            DONE: begin
               acc_r <= 64'h0;
               if (ex_ready_i) begin
                  state_r <= ALBL;
               end else begin
                  state_r <= DONE;
               end
            end
            default: begin
               if (final_s) begin
                  acc_r <= 64'h0;
                  if (ex_ready_i) begin
                     state_r <= ALBL;
                  end else begin
                     result_r <= word_s;
                     state_r  <= DONE;
                  end
               end else begin
                  acc_r   <= acc_next_s;
                  state_r <= pass_next_s;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cv32e40x_mult_seq.sv
// Directed, table-driven bench for cv32e40x_mult_seq plus multi-cycle corner sequences.
module tb_cv32e40x_mult_seq;
   import cv32e40x_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        enable_i;
   mul_op_e     operator_i;
   logic [31:0] op_a_i;
   logic [31:0] op_b_i;
   logic        ex_ready_i;
   logic [31:0] result_o;
   logic        ready_o;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      mul_op_e     op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
   } vec_t;

   vec_t vecs[11];

   cv32e40x_mult_seq dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable_i   (enable_i),
      .operator_i (operator_i),
      .op_a_i     (op_a_i),
      .op_b_i     (op_b_i),
      .ex_ready_i (ex_ready_i),
      .result_o   (result_o),
      .ready_o    (ready_o)
   );

   cv32e40x_mult_seq_checker u_chk (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable_i   (enable_i),
      .operator_i (operator_i),
      .op_a_i     (op_a_i),
      .op_b_i     (op_b_i),
      .ex_ready_i (ex_ready_i),
      .ready_o    (ready_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic int exp_lat(input mul_op_e op, input logic [31:0] a, input logic [31:0] b);
      if (op == MUL) begin
`ifdef CV32E40X_MULT_SHORT_EN
         if ((a[31:16] == 16'h0000) && (b[31:16] == 16'h0000)) return 1;
`endif
         return 3;
      end
      return 4;
   endfunction

   // Issue one instruction with ex_ready_i=1; report the cycle ready_o rose (0 = timeout)
   task automatic run_op(input mul_op_e op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res);
      @(negedge clk);
      operator_i = op;
      op_a_i     = a;
      op_b_i     = b;
      enable_i   = 1'b1;
      ex_ready_i = 1'b1;
      lat        = 0;
      res        = 32'h0;
      for (int c = 1; c <= 8; c++) begin
         #2;
         if (ready_o) begin
            lat = c;
            res = result_o;
            break;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      int          lat;
      logic [31:0] res;

      vecs[0]  = '{MUL,    32'h0001_0003, 32'h0002_0005, 32'h000B_000F};
      vecs[1]  = '{MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
      vecs[2]  = '{MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      vecs[3]  = '{MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
      vecs[4]  = '{MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
      vecs[5]  = '{MUL,    32'h0000_0003, 32'h0000_0005, 32'h0000_000F};
      vecs[6]  = '{MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
      vecs[7]  = '{MULHU,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001};
      vecs[8]  = '{MULH,   32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000};
      vecs[9]  = '{MULHSU, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000};
      vecs[10] = '{MUL,    32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001};

      rst_n      = 1'b0;
      enable_i   = 1'b0;
      ex_ready_i = 1'b0;
      operator_i = MUL;
      op_a_i     = 32'h0;
      op_b_i     = 32'h0;
      repeat (2) @(negedge clk);
      #2;
      check("reset_ready", {31'h0, ready_o}, 32'h1);
      check("reset_result", result_o, 32'h0);
      rst_n = 1'b1;

      // Back-to-back table of directed vectors
      foreach (vecs[i]) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, res);
         check($sformatf("vec%0d_latency", i), lat, exp_lat(vecs[i].op, vecs[i].a, vecs[i].b));
         check($sformatf("vec%0d_result", i), res, vecs[i].res);
      end
      @(negedge clk);
      enable_i = 1'b0;

      // Result held in DONE while EX stalls, then the next MUL follows directly
      @(negedge clk);
      operator_i = MULH;
      op_a_i     = 32'h8000_0000;
      op_b_i     = 32'h8000_0000;
      enable_i   = 1'b1;
      ex_ready_i = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         #2;
         check($sformatf("hold_busy_c%0d", c), {31'h0, ready_o}, 32'h0);
         @(negedge clk);
      end
      #2;
      check("hold_final_ready", {31'h0, ready_o}, 32'h1);
      check("hold_final_result", result_o, 32'h4000_0000);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #2;
         check($sformatf("hold_done_ready_%0d", k), {31'h0, ready_o}, 32'h1);
         check($sformatf("hold_done_result_%0d", k), result_o, 32'h4000_0000);
      end
      @(negedge clk);
      ex_ready_i = 1'b1;
      #2;
      check("hold_accept_result", result_o, 32'h4000_0000);
      run_op(MUL, 32'h0000_0003, 32'h0000_0005, lat, res);
      check("after_hold_latency", lat, exp_lat(MUL, 32'h3, 32'h5));
      check("after_hold_result", res, 32'h0000_000F);
      @(negedge clk);
      enable_i = 1'b0;

      // Flush during the AHBL pass must leave no partial sum behind
      @(negedge clk);
      operator_i = MULH;
      op_a_i     = 32'h8000_0000;
      op_b_i     = 32'h8000_0000;
      enable_i   = 1'b1;
      ex_ready_i = 1'b1;
      @(negedge clk);
      @(negedge clk);
      enable_i = 1'b0;
      #2;
      check("flush_ready", {31'h0, ready_o}, 32'h1);
      check("flush_result", result_o, 32'h0);
      run_op(MUL, 32'h0000_0003, 32'h0000_0005, lat, res);
      check("after_flush_latency", lat, exp_lat(MUL, 32'h3, 32'h5));
      check("after_flush_result", res, 32'h0000_000F);
      @(negedge clk);
      enable_i = 1'b0;

      // Asynchronous reset in the final MUL pass drops back to the ALBL pass at once
      run_op(MUL, 32'h0001_0003, 32'h0002_0005, lat, res);
      check("pre_reset_latency", lat, exp_lat(MUL, 32'h0001_0003, 32'h0002_0005));
      rst_n = 1'b0;
      #1;
      check("async_reset_state_ready", {31'h0, ready_o}, {31'h0, (exp_lat(MUL, 32'h0001_0003, 32'h0002_0005) == 1)});
      @(negedge clk);
      enable_i = 1'b0;
      rst_n    = 1'b1;

      // Reset during the ALBH pass, then a fresh MULHU
      @(negedge clk);
      operator_i = MULHU;
      op_a_i     = 32'hFFFF_FFFF;
      op_b_i     = 32'hFFFF_FFFF;
      enable_i   = 1'b1;
      @(negedge clk);
      #2;
      rst_n    = 1'b0;
      enable_i = 1'b0;
      #1;
      check("reset_mid_ready", {31'h0, ready_o}, 32'h1);
      check("reset_mid_result", result_o, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(MULHU, 32'h0001_0000, 32'h0001_0000, lat, res);
      check("after_reset_latency", lat, 32'd4);
      check("after_reset_result", res, 32'h0000_0001);
      @(negedge clk);
      enable_i = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
